// File: rtl/cordic_ahb_master_pkg.sv
// Shared definitions for the CORDIC AHB-Lite initiator: FSM states, AHB
// transfer encodings, slave register offsets and status bit positions.
// No ports; imported by cordic_ahb_master.
package cordic_ahb_master_pkg;

  // One state per AHB address/data phase of each access, plus IDLE and RSP.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    WR_D = 3'd2,
    ST_A = 3'd3,
    ST_D = 3'd4,
    RD_A = 3'd5,
    RD_D = 3'd6,
    RSP  = 3'd7
  } state_t;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  localparam logic [31:0] DATA_OFF      = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF    = 32'h0000_0004;

  localparam int          EMPTY_BIT     = 0;

endpackage

// File: rtl/cordic_ahb_master.sv
// Purpose: AHB-Lite initiator that writes one operand to the CORDIC slave,
//          polls its status until a result is ready, then reads the result.
// Latency: 7 cycles handshake-to-rsp_valid with a zero-wait slave and
//          non-empty first poll; +1 per wait state, +2 per extra poll.
// Backpressure: one command in flight; cmd_ready only in IDLE, the response
//          is held until rsp_ready, AHB stays idle while waiting.
// Ports: clk/reset (sync, active-high); cmd_valid/cmd_ready/cmd_data operand
//        input; rsp_valid/rsp_ready/rsp_data/rsp_err result output;
//        H* AHB-Lite manager signals (HSIZE/HBURST/HPROT/HMASTLOCK constant).
module cordic_ahb_master
  import cordic_ahb_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          POLL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int                CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(POLL_LIMIT);

  state_t            state_q, state_d;
  logic [31:0]       op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  // Saturating increment so the counter can never wrap past the limit.
  assign cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;

  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  // Operand register drives write data directly, so it is stable for the
  // whole (possibly stretched) WR_D data phase.
  assign HWDATA    = op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Address-phase outputs decode from state only; state cannot leave an
  // address phase while HREADY=0, which holds HADDR/HWRITE/HTRANS.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    HTRANS     = HTRANS_IDLE;
    HADDR      = '0;
    HWRITE     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d       = cmd_data;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = WR_A;
        end
      end
      WR_A: begin
        HTRANS = HTRANS_NONSEQ;
        HWRITE = 1'b1;
        HADDR  = BASE_ADDR + DATA_OFF;
        if (HREADY) state_d = WR_D;
      end
      WR_D: begin
        if (HREADY) begin
          if (HRESP) begin
            rsp_err_d = 1'b1;
            state_d   = RSP;
          end else begin
            state_d   = ST_A;
          end
        end
      end
      ST_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = BASE_ADDR + STATUS_OFF;
        if (HREADY) state_d = ST_D;
      end
      ST_D: begin
        if (HREADY) begin
          if (HRESP) begin
            rsp_err_d = 1'b1;
            state_d   = RSP;
          end else if (!HRDATA[EMPTY_BIT]) begin
            state_d   = RD_A;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == LIMIT) begin
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
              state_d    = RSP;
            end else begin
              state_d    = ST_A;
            end
          end
        end
      end
      RD_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = BASE_ADDR + DATA_OFF;
        if (HREADY) state_d = RD_D;
      end
      RD_D: begin
        if (HREADY) begin
          rsp_data_d = HRDATA;
          rsp_err_d  = HRESP;
          state_d    = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_ahb_master.sv
// Bench for cordic_ahb_master: a behavioural CORDIC slave with random wait
// states and a per-command reference of the expected bus traffic, response
// and latency, plus directed cases for polling, timeout, errors, response
// backpressure and reset during a status access.
module tb_cordic_ahb_master;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          LIMIT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_ahb_master #(.BASE_ADDR(BASE), .POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Slave configuration for the current command.
  logic [31:0] cur_op;
  int          cfg_n_empty = 0;
  bit          cfg_wr_err = 0, cfg_st_err = 0, cfg_rd_err = 0;
  logic [31:0] cfg_rd_val = '0;
  int          cfg_wr_wait = -1;
  int          cfg_max_wait = 0;

  // Slave observations.
  int n_wr, n_st, n_rd, n_wait, n_bad, hwdata_bad, st_idx;

  bit          dp_active = 0;
  logic [31:0] dp_addr;
  bit          dp_write;
  int          dp_wait;

  // Slave works at the falling edge: it sees the manager's outputs for the
  // current cycle and sets HREADY/HRESP/HRDATA sampled at the next rise.
  always @(negedge clk) begin
    logic [31:0] r;
    if (reset) begin
      dp_active = 0;
      HREADY    = 1'b1;
      HRESP     = 1'b0;
    end else begin
      if (dp_active) begin
        if (dp_write && HWDATA !== cur_op) hwdata_bad++;
        if (dp_wait > 0) begin
          HREADY = 1'b0;
          HRESP  = 1'b0;
          dp_wait--;
          n_wait++;
        end else begin
          HREADY = 1'b1;
          r = $urandom;
          if (dp_write) begin
            if (dp_addr != BASE) n_bad++;
            n_wr++;
            HRESP  = cfg_wr_err;
            HRDATA = r;
          end else if (dp_addr == BASE + 32'd4) begin
            HRESP  = cfg_st_err && (st_idx == 0);
            HRDATA = {r[31:1], (st_idx < cfg_n_empty)};
            st_idx++;
            n_st++;
          end else if (dp_addr == BASE) begin
            n_rd++;
            HRESP  = cfg_rd_err;
            HRDATA = cfg_rd_val;
          end else begin
            n_bad++;
            HRESP = 1'b1;
          end
          dp_active = 0;
        end
      end else begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end
      if (HTRANS == 2'b10 && rsp_valid) n_bad++;
      if (HTRANS == 2'b10 && HREADY) begin
        dp_active = 1;
        dp_addr   = HADDR;
        dp_write  = HWRITE;
        if (HWRITE && cfg_wr_wait >= 0) dp_wait = cfg_wr_wait;
        else dp_wait = $urandom_range(cfg_max_wait, 0);
      end
    end
  end

  // One command end to end; called and returns at a falling edge.
  task automatic run_cmd(input string nm, input logic [31:0] op, input int n_empty,
                         input bit wr_err, input bit st_err, input bit rd_err,
                         input logic [31:0] rd_val, input int wr_wait,
                         input int max_wait, input int hold);
    int exp_st, exp_rd, lat, t, ready_in_flight, unstable;
    bit exp_err, chk_data;
    logic [31:0] exp_data, held_data;
    logic        held_err;
    cur_op = op; cfg_n_empty = n_empty; cfg_wr_err = wr_err; cfg_st_err = st_err;
    cfg_rd_err = rd_err; cfg_rd_val = rd_val; cfg_wr_wait = wr_wait;
    cfg_max_wait = max_wait;
    n_wr = 0; n_st = 0; n_rd = 0; n_wait = 0; n_bad = 0; hwdata_bad = 0; st_idx = 0;
    exp_data = '0; chk_data = 1;
    if (wr_err) begin
      exp_st = 0; exp_rd = 0; exp_err = 1; chk_data = 0;
    end else if (st_err) begin
      exp_st = 1; exp_rd = 0; exp_err = 1; chk_data = 0;
    end else if (n_empty >= LIMIT) begin
      exp_st = LIMIT; exp_rd = 0; exp_err = 1; exp_data = '0;
    end else begin
      exp_st = n_empty + 1; exp_rd = 1; exp_err = rd_err; exp_data = rd_val;
    end

    cmd_valid = 1'b1;
    cmd_data  = op;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk({nm, ".accept"}, cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'($urandom_range(1, 0));
    cmd_data  = $urandom;
    lat = 1;
    ready_in_flight = 0;
    while (!rsp_valid && lat < 400) begin
      if (cmd_ready) ready_in_flight++;
      @(negedge clk);
      lat++;
      cmd_data = $urandom;
    end
    chk({nm, ".rsp_valid"}, rsp_valid, 1'b1);
    chk({nm, ".latency"}, lat, 1 + 2 * (1 + exp_st + exp_rd) + n_wait);
    chk({nm, ".rsp_err"}, rsp_err, exp_err);
    if (chk_data) chk({nm, ".rsp_data"}, rsp_data, exp_data);
    chk({nm, ".n_wr"}, n_wr, 1);
    chk({nm, ".n_st"}, n_st, exp_st);
    chk({nm, ".n_rd"}, n_rd, exp_rd);
    chk({nm, ".hwdata"}, hwdata_bad, 0);
    chk({nm, ".busy_rdy"}, ready_in_flight, 0);

    cmd_valid = 1'b1;
    held_data = rsp_data;
    held_err  = rsp_err;
    unstable  = 0;
    for (int i = 0; i < hold; i++) begin
      if (!rsp_valid || rsp_data !== held_data || rsp_err !== held_err ||
          cmd_ready || HTRANS != 2'b00) unstable++;
      @(negedge clk);
    end
    chk({nm, ".hold"}, unstable, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, ".rsp_drop"}, rsp_valid, 1'b0);
    chk({nm, ".rdy_after"}, cmd_ready, 1'b1);
    chk({nm, ".no_bad_xfer"}, n_bad, 0);
    cmd_valid = 1'b0;
    cfg_wr_wait = -1;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst.cmd_ready", cmd_ready, 1'b1);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.rsp_err", rsp_err, 1'b0);
    chk("rst.rsp_data", rsp_data, 32'h0);
    chk("rst.htrans", HTRANS, 2'b00);
    chk("rst.haddr", HADDR, 32'h0);
    chk("rst.hwrite", HWRITE, 1'b0);
    chk("rst.hwdata", HWDATA, 32'h0);
    chk("const.hsize", HSIZE, 3'b010);
    chk("const.hburst", HBURST, 3'b000);
    chk("const.hprot", HPROT, 4'b0011);
    chk("const.hmastlock", HMASTLOCK, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_cmd("basic", 32'h1234_0000, 0, 0, 0, 0, 32'h0000_5A5A, -1, 0, 0);
    run_cmd("poll3", 32'h0BAD_CAFE, 3, 0, 0, 0, 32'h1357_9BDF, -1, 0, 0);
    run_cmd("timeout", 32'h0000_FFFF, 40, 0, 0, 0, 32'hDEAD_BEEF, -1, 0, 0);
    run_cmd("wr_err", 32'hA5A5_5A5A, 0, 1, 0, 0, 32'h1111_2222, 2, 0, 0);
    run_cmd("backpr", 32'h7777_0001, 1, 0, 0, 0, 32'h8642_0000, -1, 0, 5);
    run_cmd("st_err", 32'h0F0F_0F0F, 2, 0, 1, 0, 32'h2222_3333, -1, 1, 1);
    run_cmd("rd_err", 32'h4444_5555, 0, 0, 0, 1, 32'h6666_7777, -1, 2, 2);

    // Reset during a status address phase.
    cfg_n_empty = 0; cfg_wr_err = 0; cfg_st_err = 0; cfg_rd_err = 0;
    cfg_max_wait = 0; cur_op = 32'hC0DE_0001;
    cmd_valid = 1'b1;
    cmd_data  = cur_op;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!(HTRANS == 2'b10 && HADDR == BASE + 32'd4) && t < 50) begin
      @(negedge clk); t++;
    end
    chk("rst_st_a.reached", HADDR, BASE + 32'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_st_a.htrans", HTRANS, 2'b00);
    chk("rst_st_a.cmd_ready", cmd_ready, 1'b1);
    chk("rst_st_a.rsp_valid", rsp_valid, 1'b0);
    chk("rst_st_a.haddr", HADDR, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomised commands.
    for (int k = 0; k < 30; k++) begin
      int ne;
      ne = ($urandom_range(7, 0) == 0) ? $urandom_range(20, 14) : $urandom_range(4, 0);
      run_cmd($sformatf("rnd%0d", k), $urandom, ne,
              $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0,
              $urandom_range(9, 0) == 0, $urandom, -1,
              $urandom_range(3, 0), $urandom_range(3, 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
